// File: rtl/pipe_pkg.sv
// Shared encodings and control-bundle type for the RV32I ID/EXE stage.
package pipe_pkg;

    typedef enum logic [2:0] {
        R_TYPE     = 3'b000,
        I_TYPE     = 3'b001,
        ADD_TYPE   = 3'b010,
        I_JAL_TYPE = 3'b011,
        B_TYPE     = 3'b100,
        U_LUI_TYPE = 3'b101
    } alu_ctrl_op_e;

    typedef enum logic [1:0] {
        N_BRANCH   = 2'b00,
        JAL_BRANCH = 2'b01,
        B_BRANCH   = 2'b10,
        J_BRANCH   = 2'b11
    } branch_signal_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_type_e;

    typedef struct packed {
        alu_ctrl_op_e   alu_ctrl_op;
        logic           exe_pc_sel;
        logic           alu_rs2_sel;
        logic           mem_rd_sel;
        branch_signal_e branch_signal;
        logic           dm_read;
        logic           dm_write;
        logic           reg_file_write;
        logic           wb_data_sel;
    } ctrl_bundle_t;

    // A bubble must look like a harmless ADD with no side effects.
    localparam ctrl_bundle_t CTRL_BUBBLE = '{
        alu_ctrl_op:    ADD_TYPE,
        exe_pc_sel:     1'b0,
        alu_rs2_sel:    1'b0,
        mem_rd_sel:     1'b0,
        branch_signal:  N_BRANCH,
        dm_read:        1'b0,
        dm_write:       1'b0,
        reg_file_write: 1'b0,
        wb_data_sel:    1'b0
    };

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection between the load sitting in EXE and the ID instruction.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       exe_valid,
    input  logic       exe_dm_read,
    input  logic [4:0] exe_rd_addr,
    input  logic       id_valid,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       flush,
    input  logic       stall,
    output logic       haz,
    output logic       ld_use_stall
);

    logic rd_match;

    assign rd_match = (exe_rd_addr == id_rs1_addr) | (exe_rd_addr == id_rs2_addr);

    // x0 never carries a real dependency, so a load to x0 cannot stall.
    assign haz = exe_valid & exe_dm_read & (exe_rd_addr != 5'd0) & id_valid & rd_match;

    assign ld_use_stall = haz & ~flush & ~stall;

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID/EXE pipeline register with load-use bubble insertion, flush squash and a
// saturating bubble counter.
module id_exe_pipe_reg
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             ID_valid,
    input  logic [XLEN-1:0]  ID_pc,
    input  logic [XLEN-1:0]  ID_rs1_data,
    input  logic [XLEN-1:0]  ID_rs2_data,
    input  logic [XLEN-1:0]  ID_imm,
    input  logic [4:0]       ID_rs1_addr,
    input  logic [4:0]       ID_rs2_addr,
    input  logic [4:0]       ID_rd_addr,
    input  logic [2:0]       ID_funct3,
    input  logic             ID_funct7_b5,
    input  logic [2:0]       ID_ALU_Ctrl_op,
    input  logic             ID_EXE_pc_sel,
    input  logic             ID_ALU_rs2_sel,
    input  logic             ID_MEM_rd_sel,
    input  logic             ID_DM_read,
    input  logic             ID_DM_write,
    input  logic             ID_reg_file_write,
    input  logic             ID_WB_data_sel,
    input  logic [1:0]       ID_branch_signal,
    output logic             EXE_valid,
    output logic [XLEN-1:0]  EXE_pc,
    output logic [XLEN-1:0]  EXE_rs1_data,
    output logic [XLEN-1:0]  EXE_rs2_data,
    output logic [XLEN-1:0]  EXE_imm,
    output logic [4:0]       EXE_rs1_addr,
    output logic [4:0]       EXE_rs2_addr,
    output logic [4:0]       EXE_rd_addr,
    output logic [2:0]       EXE_funct3,
    output logic             EXE_funct7_b5,
    output logic [2:0]       EXE_ALU_Ctrl_op,
    output logic             EXE_EXE_pc_sel,
    output logic             EXE_ALU_rs2_sel,
    output logic             EXE_MEM_rd_sel,
    output logic             EXE_DM_read,
    output logic             EXE_DM_write,
    output logic             EXE_reg_file_write,
    output logic             EXE_WB_data_sel,
    output logic [1:0]       EXE_branch_signal,
    output logic             ld_use_stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [2:0]      funct3;
        logic            funct7_b5;
    } data_bundle_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    ctrl_bundle_t     id_ctrl;
    ctrl_bundle_t     exe_ctrl_q;
    data_bundle_t     id_data;
    data_bundle_t     exe_data_q;
    logic             exe_valid_q;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic             haz;
    logic             hold;
    logic             load_bubble;
    logic             count_bubble;

    assign id_ctrl = '{
        alu_ctrl_op:    alu_ctrl_op_e'(ID_ALU_Ctrl_op),
        exe_pc_sel:     ID_EXE_pc_sel,
        alu_rs2_sel:    ID_ALU_rs2_sel,
        mem_rd_sel:     ID_MEM_rd_sel,
        branch_signal:  branch_signal_e'(ID_branch_signal),
        dm_read:        ID_DM_read,
        dm_write:       ID_DM_write,
        reg_file_write: ID_reg_file_write,
        wb_data_sel:    ID_WB_data_sel
    };

    assign id_data = '{
        pc:        ID_pc,
        rs1_data:  ID_rs1_data,
        rs2_data:  ID_rs2_data,
        imm:       ID_imm,
        rs1_addr:  ID_rs1_addr,
        rs2_addr:  ID_rs2_addr,
        rd_addr:   ID_rd_addr,
        funct3:    ID_funct3,
        funct7_b5: ID_funct7_b5
    };

    load_use_detect u_load_use_detect (
        .exe_valid    (exe_valid_q),
        .exe_dm_read  (exe_ctrl_q.dm_read),
        .exe_rd_addr  (exe_data_q.rd_addr),
        .id_valid     (ID_valid),
        .id_rs1_addr  (ID_rs1_addr),
        .id_rs2_addr  (ID_rs2_addr),
        .flush        (flush),
        .stall        (stall),
        .haz          (haz),
        .ld_use_stall (ld_use_stall)
    );

    // Flush overrides stall; an empty ID slot becomes a bubble but is not counted.
    assign hold         = stall & ~flush;
    assign count_bubble = flush | haz;
    assign load_bubble  = count_bubble | ~ID_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_valid_q  <= 1'b0;
            exe_ctrl_q   <= CTRL_BUBBLE;
            exe_data_q   <= '0;
            bubble_cnt_q <= '0;
        end else if (!hold) begin
            exe_valid_q <= ~load_bubble;
            exe_ctrl_q  <= load_bubble ? CTRL_BUBBLE : id_ctrl;
            exe_data_q  <= load_bubble ? data_bundle_t'('0) : id_data;
            if (count_bubble) begin
                bubble_cnt_q <= sat_inc(bubble_cnt_q);
            end
        end
    end

    assign EXE_valid          = exe_valid_q;
    assign EXE_pc             = exe_data_q.pc;
    assign EXE_rs1_data       = exe_data_q.rs1_data;
    assign EXE_rs2_data       = exe_data_q.rs2_data;
    assign EXE_imm            = exe_data_q.imm;
    assign EXE_rs1_addr       = exe_data_q.rs1_addr;
    assign EXE_rs2_addr       = exe_data_q.rs2_addr;
    assign EXE_rd_addr        = exe_data_q.rd_addr;
    assign EXE_funct3         = exe_data_q.funct3;
    assign EXE_funct7_b5      = exe_data_q.funct7_b5;
    assign EXE_ALU_Ctrl_op    = exe_ctrl_q.alu_ctrl_op;
    assign EXE_EXE_pc_sel     = exe_ctrl_q.exe_pc_sel;
    assign EXE_ALU_rs2_sel    = exe_ctrl_q.alu_rs2_sel;
    assign EXE_MEM_rd_sel     = exe_ctrl_q.mem_rd_sel;
    assign EXE_DM_read        = exe_ctrl_q.dm_read;
    assign EXE_DM_write       = exe_ctrl_q.dm_write;
    assign EXE_reg_file_write = exe_ctrl_q.reg_file_write;
    assign EXE_WB_data_sel    = exe_ctrl_q.wb_data_sel;
    assign EXE_branch_signal  = exe_ctrl_q.branch_signal;
    assign bubble_cnt         = bubble_cnt_q;

endmodule
